// File: rtl/life_gen_sequencer_if.sv
// Control/status bundle between user controls,
// the generation sequencer and the cell array.
interface life_gen_sequencer_if #(
    parameter int RATE_W = 4,
    parameter int GEN_W  = 16
);
    logic              run;
    logic              step;
    logic [RATE_W-1:0] rate;
    logic [2:0]        tick;
    logic              tick_stb;
    logic              commit;
    logic [GEN_W-1:0]  gen_count;
    logic              busy;
    logic [1:0]        state;

    modport master (
        output run,
        output step,
        output rate,
        input  tick,
        input  tick_stb,
        input  commit,
        input  gen_count,
        input  busy,
        input  state
    );

    modport slave (
        input  run,
        input  step,
        input  rate,
        output tick,
        output tick_stb,
        output commit,
        output gen_count,
        output busy,
        output state
    );
endinterface

// File: rtl/life_gen_sequencer.sv
// Game of Life 8-tick sweep sequencer: tick phase,
// prescaled tick strobe, generation commit and count.
module life_gen_sequencer #(
    parameter int RATE_W = 4,
    parameter int GEN_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    life_gen_sequencer_if.slave  bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] STEP  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam logic [RATE_W-1:0] PS_ONE  = 1;
    localparam logic [GEN_W-1:0]  GEN_ONE = 1;

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [2:0]        tick_q;
    logic [RATE_W-1:0] presc_q;
    logic [RATE_W-1:0] rate_q;
    logic [GEN_W-1:0]  gen_q;
    logic              tick_stb;
    logic              commit;
    logic              busy;

    assign busy     = (state_q != IDLE);
    assign tick_stb = busy && (presc_q == rate_q);
    assign commit   = tick_stb && (tick_q == 3'd7);

    assign bus.tick      = tick_q;
    assign bus.tick_stb  = tick_stb;
    assign bus.commit    = commit;
    assign bus.gen_count = gen_q;
    assign bus.busy      = busy;
    assign bus.state     = state_q;

    // A sweep only ends on commit; run decides what follows it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.run)
                    state_d = RUN;
                else if (bus.step)
                    state_d = STEP;
            end
            RUN: begin
                if (commit)
                    state_d = bus.run ? RUN : IDLE;
                else if (!bus.run)
                    state_d = DRAIN;
            end
            STEP: begin
                if (commit)
                    state_d = IDLE;
                else if (bus.run)
                    state_d = RUN;
            end
            DRAIN: begin
                if (commit)
                    state_d = bus.run ? RUN : IDLE;
                else if (bus.run)
                    state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= 3'd0;
            presc_q <= '0;
            rate_q  <= '0;
            gen_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                tick_q  <= 3'd0;
                presc_q <= '0;
                if (state_d != IDLE)
                    rate_q <= bus.rate;
            end else begin
                if (tick_stb) begin
                    presc_q <= '0;
                    tick_q  <= tick_q + 3'd1;
                end else begin
                    presc_q <= presc_q + PS_ONE;
                end
                // New rate only lands on a sweep boundary.
                if (commit) begin
                    rate_q <= bus.rate;
                    gen_q  <= gen_q + GEN_ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_life_gen_sequencer.sv
// Bench for life_gen_sequencer: sweep-position model,
// directed scenarios and randomized control traffic.
module tb_life_gen_sequencer;
    logic clk;
    logic rst;

    life_gen_sequencer_if #(.RATE_W(4), .GEN_W(16)) a ();
    life_gen_sequencer_if #(.RATE_W(4), .GEN_W(2))  b ();

    assign b.run  = a.run;
    assign b.step = a.step;
    assign b.rate = a.rate;

    life_gen_sequencer #(.RATE_W(4), .GEN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (a)
    );

    life_gen_sequencer #(.RATE_W(4), .GEN_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", nm, $time);
    endtask

    // Model: position within the sweep and cycles per tick.
    int          m_state = 0;
    int          m_pos   = 0;
    int          m_per   = 1;
    int unsigned m_gen   = 0;
    int          m_ns;
    bit          m_c;

    function automatic int m_tick();
        return (m_state == 0) ? 0 : m_pos / m_per;
    endfunction

    function automatic bit m_stb();
        return (m_state != 0) && ((m_pos % m_per) == m_per - 1);
    endfunction

    function automatic bit m_commit();
        return m_stb() && (m_pos == 8 * m_per - 1);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0;
            m_pos   = 0;
            m_per   = 1;
            m_gen   = 0;
        end else if (m_state == 0) begin
            m_pos = 0;
            m_per = int'(a.rate) + 1;
            if (a.run)
                m_state = 1;
            else if (a.step)
                m_state = 2;
        end else begin
            m_c = m_commit();
            if (m_state == 2)
                m_ns = m_c ? 0 : (a.run ? 1 : 2);
            else
                m_ns = m_c ? (a.run ? 1 : 0) : (a.run ? 1 : 3);
            if (m_c) begin
                m_gen++;
                m_pos = 0;
                m_per = int'(a.rate) + 1;
            end else begin
                m_pos++;
            end
            m_state = m_ns;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tick",      a.tick,      m_tick());
            chk("tick_stb",  a.tick_stb,  m_stb());
            chk("commit",    a.commit,    m_commit());
            chk("state",     a.state,     m_state);
            chk("busy",      a.busy,      m_state != 0);
            chk("gen_count", a.gen_count, m_gen % 65536);
            chk("gen2",      b.gen_count, m_gen % 4);
            chk("state2",    b.state,     m_state);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_tick(input int t, input int bound);
        int k;
        for (k = 0; k < bound; k++) begin
            @(negedge clk);
            if (m_state != 0 && m_tick() == t) break;
        end
        if (k == bound) timeout("wait_tick");
    endtask

    task automatic wait_idle(input int bound);
        int k;
        for (k = 0; k < bound; k++) begin
            @(negedge clk);
            if (m_state == 0) break;
        end
        if (k == bound) timeout("wait_idle");
    endtask

    task automatic wait_commit(input int bound);
        int k;
        for (k = 0; k < bound; k++) begin
            @(negedge clk);
            if (a.commit) break;
        end
        if (k == bound) timeout("wait_commit");
    endtask

    int nstb;
    int ncom;
    int c1;
    int c2;
    int wrap_exp [5];

    initial begin
        rst    = 1'b1;
        a.run  = 1'b0;
        a.step = 1'b0;
        a.rate = '0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        // idle after reset
        repeat (20) @(negedge clk);
        chk("idle_gen", a.gen_count, 0);
        chk("idle_state", a.state, 0);
        chk("idle_tick", a.tick, 0);

        // single step at rate 0, second step mid-sweep dropped
        a.step = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("step_tick", a.tick, i);
            chk("step_stb", a.tick_stb, 1);
            chk("step_commit", a.commit, i == 7);
            a.step = (i == 3);
        end
        @(negedge clk);
        chk("step_gen", a.gen_count, 1);
        chk("step_idle", a.state, 0);
        repeat (10) @(negedge clk);
        chk("step_gen_hold", a.gen_count, 1);

        // free run at rate 3 for 100 cycles
        do_reset();
        a.rate = 4'd3;
        a.run  = 1'b1;
        nstb   = 0;
        ncom   = 0;
        repeat (100) begin
            @(negedge clk);
            nstb += int'(a.tick_stb);
            ncom += int'(a.commit);
        end
        chk("free_gen", a.gen_count, 3);
        chk("free_stb", nstb, 25);
        chk("free_commit", ncom, 3);
        a.run = 1'b0;
        wait_idle(64);

        // drain to idle, then drain rescued by run
        do_reset();
        a.rate = 4'd1;
        a.run  = 1'b1;
        wait_tick(2, 40);
        a.run = 1'b0;
        @(negedge clk);
        chk("drain_state", a.state, 3);
        wait_idle(40);
        chk("drain_gen", a.gen_count, 1);
        a.run = 1'b1;
        wait_tick(2, 40);
        a.run = 1'b0;
        wait_tick(5, 40);
        a.run = 1'b1;
        @(negedge clk);
        chk("drain_rerun", a.state, 1);
        a.run = 1'b0;
        wait_idle(40);
        chk("drain_gen2", a.gen_count, 2);

        // rate change mid-sweep applies at next sweep
        do_reset();
        a.rate = 4'd0;
        a.run  = 1'b1;
        c1 = -1;
        c2 = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k <= 8 && m_tick() == 3) a.rate = 4'd2;
            if (a.commit) begin
                if (c1 < 0) c1 = k;
                else if (c2 < 0) c2 = k;
            end
        end
        chk("rate_commit1", c1, 8);
        chk("rate_commit2", c2, 32);
        a.run = 1'b0;
        wait_idle(64);
        a.rate = 4'd0;

        // reset mid-sweep
        do_reset();
        a.run = 1'b1;
        wait_tick(6, 20);
        rst   = 1'b1;
        a.run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_tick", a.tick, 0);
        chk("rst_stb", a.tick_stb, 0);
        chk("rst_commit", a.commit, 0);
        chk("rst_state", a.state, 0);
        chk("rst_gen", a.gen_count, 0);

        // 2-bit counter wrap
        wrap_exp = '{1, 2, 3, 0, 1};
        a.rate = 4'd0;
        a.run  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_commit(20);
            @(negedge clk);
            chk("wrap_gen", b.gen_count, wrap_exp[k]);
        end
        a.run = 1'b0;
        wait_idle(20);

        // randomized controls
        repeat (4000) begin
            @(negedge clk);
            rst = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 29) == 0) a.run = ~a.run;
            a.step = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0)
                a.rate = ($urandom_range(0, 7) == 0) ?
                         4'($urandom_range(0, 15)) :
                         4'($urandom_range(0, 3));
        end
        rst    = 1'b0;
        a.run  = 1'b0;
        a.step = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/life_gen_sequencer.md
Name: life_gen_sequencer

Overview:
- Controller that sequences the Game of Life 8-tick generation sweep: decides when the 3-bit tick phase advances, how fast it advances, and when a generation is committed.
- Supports free-run, single-step and graceful stop. Never abandons a sweep mid-way except on reset.
- Sits between the user controls (run switch, step button) and the cell array, which consumes tick, tick_stb and commit.

Parameters:
- RATE_W, 4, width of the rate input; each tick lasts rate+1 clock cycles.
- GEN_W, 16, width of the generation counter.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  level; 1 requests continuous generations.
- step  input  1  single-cycle pulse; requests exactly one generation when idle.
- rate  input  RATE_W  tick period minus one, in clk cycles.
- tick  output  3  current tick phase, 0..7.
- tick_stb  output  1  one-cycle pulse on the last cycle of each tick.
- commit  output  1  one-cycle pulse: tick_stb while tick==7; the cell array latches the new generation.
- gen_count  output  GEN_W  generations committed since reset, wraps modulo 2^GEN_W.
- busy  output  1  high whenever state != IDLE.
- state  output  2  IDLE=0, RUN=1, STEP=2, DRAIN=3.

Behaviour:
- Reset: synchronous, active-high. On any posedge with rst=1, the next state is:
  - state=IDLE, tick=0, prescaler=0, rate_q=0, gen_count=0.
  - tick_stb=0, commit=0, busy=0.
  - This holds mid-sweep too: no commit pulse is emitted and the sweep is abandoned.
- Registers: state, tick[2:0], prescaler[RATE_W-1:0], rate_q[RATE_W-1:0], gen_count.
- tick_stb, commit and busy are combinational from these registers.
- tick_stb = (state != IDLE) && (prescaler == rate_q).
- commit = tick_stb && (tick == 7).
- Prescaler:
  - In non-IDLE states it increments each cycle.
  - On tick_stb it returns to 0 and tick increments, wrapping 7 -> 0.
  - In IDLE, prescaler and tick are held at 0.
- rate_q:
  - Captured from rate on every transition out of IDLE and on every commit.
  - Changes to rate therefore take effect only at sweep boundaries.
  - One sweep lasts exactly 8*(rate_q+1) cycles.
- gen_count increments by 1 on the edge where commit=1. All-ones wraps to 0.
- Transitions, evaluated every posedge with rst=0:
  - IDLE: run=1 -> RUN. Otherwise step=1 -> STEP. Otherwise stay IDLE.
  - IDLE, run and step both high: RUN wins and the step is discarded.
  - RUN, run=0 and no commit this cycle -> DRAIN.
  - RUN, commit with run=0 -> IDLE.
  - RUN, commit with run=1 -> stay RUN; the next sweep starts immediately with no gap cycle.
  - STEP: commit -> IDLE. run=1 before commit -> RUN. step is ignored.
  - DRAIN: commit -> IDLE, or RUN if run=1 in that cycle.
  - DRAIN, run=1 without commit -> RUN.
- Latency:
  - step or run sampled in IDLE at edge N: state leaves IDLE at N.
  - First tick_stb occurs in the cycle after edge N+rate_q.
  - With rate=0, tick_stb is high in every busy cycle.
- Steps while busy are dropped, not queued.
- Glitch-free rule: tick, tick_stb and commit never change while state==IDLE. tick is always 0 in IDLE.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then run=0, step=0 for 20 cycles -> tick=0, tick_stb=0, commit=0, gen_count=0, state=0 throughout.
- Single step, rate=0:
  - Pulse step once.
  - tick runs 0..7 over 8 cycles with tick_stb high all 8.
  - commit high only in the cycle with tick==7.
  - gen_count 0 -> 1, then state=IDLE.
  - A second step pulsed mid-sweep produces no extra generation.
- Free-run, rate=3:
  - Hold run=1 for 100 cycles.
  - tick_stb occurs every 4 cycles.
  - commit occurs every 32 cycles.
  - gen_count=3 after 96 busy cycles.
- Drain:
  - rate=1, run=1, then drop run at tick=2.
  - state=DRAIN until commit at tick=7, then IDLE, with gen_count incremented exactly once.
  - Repeat, reasserting run at tick=5: state returns to RUN with no gap.
- Rate change mid-sweep: start with rate=0, change to rate=2 at tick=3 -> rest of the sweep still 1 cycle/tick; the next sweep uses 3 cycles/tick.
- Reset mid-sweep and wrap:
  - rst at tick=6 -> next cycle all outputs 0 and no commit pulse.
  - Separately, with GEN_W=2, run 5 generations -> gen_count sequence 1, 2, 3, 0, 1.
